// File: rtl/aes_pkg.sv
// Shared AES-128 constants and the sequencer FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_DATA_W     = 128;
    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_RC_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

endpackage

// File: rtl/aes_round_dp.sv
// One AES-128 encryption round plus the matching key-expansion step, purely combinational.
// Latency: 0 cycles; results settle in the same cycle as the inputs.
// Backpressure: none; the caller decides when to sample the outputs.
//
// Ports:
//   state_i      running cipher state (byte 0 in bits 127:120, column-major)
//   key_i        previous round key
//   rc_i         round index 1..10, selects the round constant
//   final_i      last round: MixColumns is bypassed
//   state_next_o SubBytes/ShiftRows/[MixColumns] result XORed with key_next_o
//   key_next_o   round key for round rc_i
module aes_round_dp
    import aes_pkg::*;
(
    input  logic [AES_DATA_W-1:0] state_i,
    input  logic [AES_DATA_W-1:0] key_i,
    input  logic [AES_RC_W-1:0]   rc_i,
    input  logic                  final_i,
    output logic [AES_DATA_W-1:0] state_next_o,
    output logic [AES_DATA_W-1:0] key_next_o
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from its algebraic definition: GF(2^8) inverse (a^254, 0 maps to 0)
    // followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [AES_RC_W-1:0] rc);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < 16; i++) begin
            if (i < int'(rc)) r = xtime(r);
        end
        return r;
    endfunction

    // Column word is {a0,a1,a2,a3} with row 0 in the top byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte n of the block (n = row + 4*col) lives in element 15-n.
    logic [15:0][7:0] st, sub, shf, mix;
    logic [3:0][31:0] kw, nk;
    logic [31:0]      rot, tmp;

    always_comb begin
        st  = state_i;
        sub = '0;
        shf = '0;
        mix = '0;
        for (int i = 0; i < 16; i++) begin
            sub[i] = sbox(st[i]);
        end
        // Row r rotates left by r positions.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shf[15 - (r + 4 * c)] = sub[15 - (r + 4 * ((c + r) % 4))];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix[15 - 4 * c -: 4] = mix_col(shf[15 - 4 * c -: 4]);
        end
    end

    // kw[3] is w0 and kw[0] is w3 of the previous round key.
    always_comb begin
        kw    = key_i;
        rot   = {kw[0][23:0], kw[0][31:24]};
        tmp   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon(rc_i), 24'h000000};
        nk    = '0;
        nk[3] = kw[3] ^ tmp;
        nk[2] = kw[2] ^ nk[3];
        nk[1] = kw[1] ^ nk[2];
        nk[0] = kw[0] ^ nk[1];
    end

    assign key_next_o   = nk;
    assign state_next_o = (final_i ? shf : mix) ^ nk;

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: initial AddRoundKey, then rounds 1..10 via an external round datapath.
// Latency: block accepted on cycle N is presented on cycle N+11; one block per 11 cycles with out_ready held.
// Backpressure: ciphertext held in DONE until out_ready; in_ready low while running or while output is stalled.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_key plaintext+key handshake
//   out_valid/out_ready/out_data    ciphertext handshake (out_data is the state register)
//   dp_state/dp_key/dp_rc/dp_final  drive the round datapath; dp_rc is 0 outside RUN
//   dp_state_next/dp_key_next       round datapath results, sampled only in RUN
//   busy, round_cnt                 status
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int DATA_W     = AES_DATA_W,
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int RC_W       = AES_RC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] dp_state,
    output logic [DATA_W-1:0] dp_key,
    output logic [RC_W-1:0]   dp_rc,
    output logic              dp_final,
    input  logic [DATA_W-1:0] dp_state_next,
    input  logic [DATA_W-1:0] dp_key_next,
    output logic              busy,
    output logic [RC_W-1:0]   round_cnt
);

    localparam logic [RC_W-1:0] LAST_RC = RC_W'(NUM_ROUNDS);

    aes_fsm_e          fsm_q, fsm_d;
    logic [DATA_W-1:0] state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [RC_W-1:0]   round_q, round_d;
    logic              accept;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    assign accept = in_valid && in_ready;

    // Next-state logic. An accept can only occur in IDLE or DONE, which lets a
    // new block start in the same cycle the previous ciphertext is taken.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        if (accept) begin
            state_d = in_data ^ in_key;
            key_d   = in_key;
            round_d = RC_W'(1);
            fsm_d   = RUN;
        end else begin
            case (fsm_q)
                IDLE: ;
                RUN: begin
                    state_d = dp_state_next;
                    key_d   = dp_key_next;
                    if (round_q == LAST_RC) begin
                        fsm_d   = DONE;
                        round_d = '0;
                    end else begin
                        round_d = round_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) fsm_d = IDLE;
                end
                default: begin
                    fsm_d   = IDLE;
                    round_d = '0;
                end
            endcase
        end
        // Safe decode: a corrupted round counter abandons the block.
        if ((round_q > LAST_RC) || (fsm_q == RUN && round_q == '0)) begin
            fsm_d   = IDLE;
            round_d = '0;
        end
    end

    // Output decode.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        dp_rc     = '0;
        dp_final  = 1'b0;
        case (fsm_q)
            IDLE: in_ready = 1'b1;
            RUN: begin
                busy     = 1'b1;
                dp_rc    = round_q;
                dp_final = (round_q == LAST_RC);
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    assign out_data  = state_q;
    assign dp_state  = state_q;
    assign dp_key    = key_q;
    assign round_cnt = round_q;

endmodule
